// File: rtl/inst_fetch.sv
// Byte-serial instruction fetch: issues four byte reads per instruction, assembles them
// little-endian and holds the result until decode accepts it or a jump redirects.
module inst_fetch (
    input  logic        clk_in,
    input  logic        rst_in,
    output logic        if_pc_enable_o,
    output logic [31:0] if_pc_o,
    input  logic [7:0]  if_inst_8bit_i,
    input  logic        mem_busy_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    input  logic        id_ready_i,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i
);

    typedef enum logic {StFetch, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [2:0]  issue_idx_q, issue_idx_d;
    logic        pending_q, pending_d;
    logic [1:0]  pend_idx_q, pend_idx_d;
    logic [31:0] buf_q, buf_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        grant;

    // Gated by rst_in so the request line is low for the whole reset interval.
    assign if_pc_enable_o = rst_in && (state_q == StFetch) && (issue_idx_q < 3'd4);
    assign if_pc_o        = pc_q + {29'd0, issue_idx_q};
    assign grant          = if_pc_enable_o && !mem_busy_i;

    assign inst_valid_o = inst_valid_q;
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        issue_idx_d  = issue_idx_q;
        pending_d    = 1'b0;
        pend_idx_d   = pend_idx_q;
        buf_d        = buf_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;

        unique case (state_q)
            StFetch: begin
                if (pending_q && mem_busy_i) begin
                    // Returned byte is invalid: rewind and re-issue it.
                    issue_idx_d = {1'b0, pend_idx_q};
                end else begin
                    if (pending_q) begin
                        buf_d[{pend_idx_q, 3'b000} +: 8] = if_inst_8bit_i;
                        if (pend_idx_q == 2'd3) begin
                            state_d      = StDone;
                            inst_valid_d = 1'b1;
                            inst_d       = buf_d;
                            inst_pc_d    = pc_q;
                        end
                    end
                    if (grant) begin
                        issue_idx_d = issue_idx_q + 3'd1;
                        pending_d   = 1'b1;
                        pend_idx_d  = issue_idx_q[1:0];
                    end
                end
            end
            StDone: begin
                if (id_ready_i && inst_valid_q) begin
                    pc_d         = pc_q + 32'd4;
                    issue_idx_d  = 3'd0;
                    inst_valid_d = 1'b0;
                    state_d      = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase

        // A redirect overrides everything, including a same-cycle decode handshake.
        if (jump_en_i) begin
            pc_d         = jump_addr_i;
            issue_idx_d  = 3'd0;
            pending_d    = 1'b0;
            inst_valid_d = 1'b0;
            state_d      = StFetch;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= StFetch;
            pc_q         <= 32'd0;
            issue_idx_q  <= 3'd0;
            pending_q    <= 1'b0;
            pend_idx_q   <= 2'd0;
            buf_q        <= 32'd0;
            inst_valid_q <= 1'b0;
            inst_q       <= 32'd0;
            inst_pc_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            issue_idx_q  <= issue_idx_d;
            pending_q    <= pending_d;
            pend_idx_q   <= pend_idx_d;
            buf_q        <= buf_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
        end
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 SHALL expose: clk_in  input  1  clock, all state updates on rising edge.
REQ-003 SHALL expose: rst_in  input  1  asynchronous active-low reset.
REQ-004 SHALL expose: if_pc_enable_o  output  1  byte-fetch request to memory controller.
REQ-005 SHALL expose: if_pc_o  output  32  byte address of current request.
REQ-006 SHALL expose: if_inst_8bit_i  input  8  byte returned by memory controller, one cycle after grant.
REQ-007 SHALL expose: mem_busy_i  input  1  memory controller serving a load/store this cycle; fetch not granted and returned byte invalid.
REQ-008 SHALL expose: inst_valid_o  output  1  assembled instruction available.
REQ-009 SHALL expose: inst_o  output  32  assembled instruction, little-endian.
REQ-010 SHALL expose: inst_pc_o  output  32  address of inst_o.
REQ-011 SHALL expose: id_ready_i  input  1  decode stage accepts inst_o this cycle.
REQ-012 SHALL expose: jump_en_i  input  1  redirect fetch.
REQ-013 SHALL expose: jump_addr_i  input  32  redirect target.

Function
REQ-014 SHALL implement states FETCH and DONE; internal pc (32), issue_idx (0..4), pending flag, pend_idx (0..3), 4-byte buffer.
REQ-015 SHALL drive if_pc_enable_o = (state==FETCH && issue_idx<4 && !pending-retry), combinationally, independent of mem_busy_i.
REQ-016 SHALL drive if_pc_o = pc + issue_idx, modulo 2^32.
REQ-017 SHALL treat a request as granted when if_pc_enable_o=1 and mem_busy_i=0; on grant: issue_idx+1, pending<=1, pend_idx<=issue_idx; otherwise pending<=0.
REQ-018 SHALL, in a cycle with pending=1 and mem_busy_i=0, write if_inst_8bit_i into buffer byte pend_idx (byte 0 = bits 7:0).
REQ-019 SHALL, in a cycle with pending=1 and mem_busy_i=1, drop the byte and set issue_idx<=pend_idx (re-issue), cancelling any grant that cycle.
REQ-020 SHALL, on accepting byte pend_idx=3, enter DONE next cycle with inst_valid_o=1, inst_o=buffer, inst_pc_o=pc; fetch latency with no contention = 5 cycles from FETCH entry to inst_valid_o.
REQ-021 SHALL hold inst_valid_o, inst_o, inst_pc_o stable in DONE until id_ready_i=1.
REQ-022 SHALL, on DONE with id_ready_i=1, set pc<=pc+4 (wrap 0xFFFFFFFC->0x00000000), issue_idx<=0, inst_valid_o<=0, return to FETCH.
REQ-023 SHALL issue no requests in DONE (if_pc_enable_o=0).
REQ-024 SHALL, on jump_en_i=1 in any state, set pc<=jump_addr_i, issue_idx<=0, pending<=0, inst_valid_o<=0, state<=FETCH; in-flight byte discarded.
REQ-025 SHALL give jump_en_i priority over id_ready_i in the same cycle; that handshake is void (decode flushes on the same jump).
REQ-026 SHALL ignore id_ready_i while inst_valid_o=0.
REQ-027 SHALL not require jump_addr_i alignment; byte addresses computed as pc+idx with wrap.

Reset
REQ-028 SHALL, while rst_in=0, asynchronously force pc=0, state=FETCH, issue_idx=0, pending=0, buffer=0, inst_valid_o=0, inst_o=0, inst_pc_o=0, if_pc_enable_o=0.
REQ-029 SHALL assert if_pc_enable_o with if_pc_o=0x00000000 in the first cycle after rst_in rises.
REQ-030 SHALL, on reset mid-fetch or in DONE, abandon all progress; no partial instruction emitted.

Verification
REQ-031 SHALL cover: reset release, bytes 0x13,0x05,0x10,0x00 at 0x0..0x3, mem_busy_i=0 -> inst_valid_o=1 on cycle 5, inst_o=0x00100513, inst_pc_o=0.
REQ-032 SHALL cover: id_ready_i=0 for 3 cycles then 1 -> inst_o held; next requests start at if_pc_o=0x4.
REQ-033 SHALL cover: mem_busy_i=1 in receive cycle of byte 2 -> byte 2 re-issued at pc+2, final inst_o correct, valid 2 cycles later.
REQ-034 SHALL cover: mem_busy_i=1 for 2 cycles during issue -> if_pc_o held, no byte written.
REQ-035 SHALL cover: jump_en_i=1, jump_addr_i=0x100 after byte 1 -> next if_pc_o=0x100, old bytes discarded; jump with id_ready_i same cycle -> pc=0x100, not 0x4.
REQ-036 SHALL cover: pc=0xFFFFFFFC accepted -> next if_pc_o=0x00000000; rst_in low mid-fetch -> all outputs 0 immediately.
